// File: rtl/reg_pipe_chain_pkg.sv
// Shared constants and helpers for the reg_pipe_chain register pipeline.
package reg_pipe_chain_pkg;

   localparam int DEPTH_MAX = 8;

   // Width of the occupancy counter: enough bits for 0..depth, never narrower than one bit.
   function automatic int count_width(input int depth);
      return ($clog2(depth + 1) < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_pipe_chain_if.sv
// Valid/ready handshake bundle: upstream in_* side and downstream out_* side of the chain.
interface reg_pipe_chain_if #(
   parameter int WIDTH = 18
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/reg_pipe_chain_pipe_stage.sv
// One pipe_stage of the chain: a data register and its valid bit.
// clear drops only the valid bit; the data register keeps its last value.
module reg_pipe_chain_pipe_stage
   import reg_pipe_chain_pkg::*;
#(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Next-state selection: clear beats load, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = valid_i;
         data_d  = data_i;
      end else begin
         valid_d = valid_q;
         data_d  = data_q;
      end
   end

   // Stage register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= {WIDTH{1'b0}};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/reg_pipe_chain.sv
// Valid/ready register chain of DEPTH stages with clock enable, flush and occupancy count.
// DEPTH=0 degenerates to a combinational pass-through.
module reg_pipe_chain
   import reg_pipe_chain_pkg::*;
#(
   parameter int  WIDTH = 18,
   parameter int  DEPTH = 1,
   localparam int CW    = count_width(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ce,
   input  logic            flush,
   reg_pipe_chain_if.slave bus,
   output logic [CW-1:0]   count
);

   if (DEPTH > DEPTH_MAX || DEPTH < 0 || WIDTH < 1) begin : g_bad_param
      $error("reg_pipe_chain: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
   end

   if (DEPTH == 0) begin : g_pass
      logic unused_s;
      assign unused_s      = clk ^ rst;
      assign bus.in_ready  = ce & ~flush & bus.out_ready;
      assign bus.out_valid = ce & ~flush & bus.in_valid;
      assign bus.out_data  = bus.in_data;
      assign count         = {CW{1'b0}};
   end else begin : g_chain
      logic [DEPTH-1:0] v_s;
      logic [DEPTH-1:0] r_s;
      logic [DEPTH-1:0] load_s;
      logic [DEPTH-1:0] vin_s;
      logic [WIDTH-1:0] din_s  [DEPTH];
      logic [WIDTH-1:0] dout_s [DEPTH];
      logic             in_xfer_s;
      logic             out_xfer_s;
      logic [CW-1:0]    count_q, count_d;

      // Readiness ripples back from out_ready so an empty slot anywhere lets upstream stages advance.
      always_comb begin : p_ready
         logic rdy_s;
         rdy_s = bus.out_ready;
         r_s   = {DEPTH{1'b0}};
         for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy_s  = ~v_s[k] | rdy_s;
            r_s[k] = rdy_s;
         end
      end

      assign load_s = {DEPTH{ce & ~flush}} & r_s;

      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         if (k == 0) begin : g_head
            assign vin_s[k] = bus.in_valid;
            assign din_s[k] = bus.in_data;
         end else begin : g_body
            assign vin_s[k] = v_s[k-1];
            assign din_s[k] = dout_s[k-1];
         end

         reg_pipe_chain_pipe_stage #(
            .WIDTH (WIDTH)
         ) u_pipe_stage (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load_s[k]),
            .clear_i (flush),
            .valid_i (vin_s[k]),
            .data_i  (din_s[k]),
            .valid_o (v_s[k]),
            .data_o  (dout_s[k])
         );
      end

      assign bus.in_ready  = ce & ~flush & r_s[0];
      assign bus.out_valid = ce & v_s[DEPTH-1];
      assign bus.out_data  = dout_s[DEPTH-1];

      assign in_xfer_s  = bus.in_valid & bus.in_ready;
      assign out_xfer_s = bus.out_valid & bus.out_ready;

      // Occupancy tracks the number of set valid bits across the chain.
      always_comb begin
         count_d = count_q;
         if (flush) begin
            count_d = {CW{1'b0}};
         end else if (in_xfer_s && !out_xfer_s) begin
            count_d = count_q + CW'(1'b1);
         end else if (out_xfer_s && !in_xfer_s) begin
            count_d = count_q - CW'(1'b1);
         end else begin
            count_d = count_q;
         end
      end

      // Occupancy register; reset overrides flush and ce.
      always_ff @(posedge clk) begin
         if (rst) begin
            count_q <= {CW{1'b0}};
         end else begin
            count_q <= count_d;
         end
      end

      assign count = count_q;
   end

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Scoreboard bench for reg_pipe_chain: four instances (DEPTH 3, 4, 2, 0) sharing one clock,
// each with a queue of accepted beats compared against emitted beats and the occupancy count.
module tb_reg_pipe_chain;
   import reg_pipe_chain_pkg::*;

   localparam int W = 18;
   localparam int N = 4;

   typedef struct {
      logic [W-1:0] d;
      int           c;
   } sb_ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] rst_s, ce_s, flush_s, in_valid_s, out_ready_s, lat_chk_s;
   logic [N-1:0] in_ready_s, out_valid_s;
   logic [W-1:0] in_data_s  [N];
   logic [W-1:0] out_data_s [N];
   logic [3:0]   count_s    [N];
   logic         mon_en = 1'b0;
   int           cyc    = 0;
   int           n_chk  = 0;
   int           n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   for (genvar i = 0; i < N; i++) begin : g_dut
      localparam int D = (i == 0) ? 3 : (i == 1) ? 4 : (i == 2) ? 2 : 0;
      logic [count_width(D)-1:0] cnt_s;
      sb_ent_t q[$];
      int      n_out = 0;

      reg_pipe_chain_if #(.WIDTH(W)) bus ();

      assign bus.in_valid   = in_valid_s[i];
      assign bus.in_data    = in_data_s[i];
      assign bus.out_ready  = out_ready_s[i];
      assign in_ready_s[i]  = bus.in_ready;
      assign out_valid_s[i] = bus.out_valid;
      assign out_data_s[i]  = bus.out_data;
      assign count_s[i]     = 4'(cnt_s);

      reg_pipe_chain #(
         .WIDTH (W),
         .DEPTH (D)
      ) u_dut (
         .clk   (clk),
         .rst   (rst_s[i]),
         .ce    (ce_s[i]),
         .flush (flush_s[i]),
         .bus   (bus),
         .count (cnt_s)
      );

      always @(negedge clk) begin
         sb_ent_t e;
         if (mon_en) begin
            check_eq($sformatf("count_d%0d", D), 32'(count_s[i]), 32'(q.size()));
            if (rst_s[i] || flush_s[i]) begin
               q.delete();
            end else begin
               if (in_valid_s[i] && in_ready_s[i]) q.push_back('{d: in_data_s[i], c: cyc});
               if (out_valid_s[i] && out_ready_s[i]) begin
                  n_out++;
                  if (q.size() == 0) begin
                     check_eq($sformatf("sb_underflow_d%0d", D), 32'(q.size()), 32'd1);
                  end else begin
                     e = q.pop_front();
                     check_eq($sformatf("sb_data_d%0d", D), 32'(out_data_s[i]), 32'(e.d));
                     if (lat_chk_s[i]) check_eq($sformatf("sb_latency_d%0d", D), 32'(cyc - e.c), 32'(D));
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      int acc;
      rst_s       = '1;
      ce_s        = '1;
      flush_s     = '0;
      in_valid_s  = '0;
      out_ready_s = '1;
      lat_chk_s   = '0;
      for (int i = 0; i < N; i++) in_data_s[i] = '0;
      tick();
      tick();
      rst_s  = '0;
      #1;
      mon_en = 1'b1;
      for (int i = 0; i < N; i++) begin
         check_eq("rst_count", 32'(count_s[i]), 32'd0);
         check_eq("rst_out_valid", 32'(out_valid_s[i]), 32'd0);
         check_eq("rst_in_ready", 32'(in_ready_s[i]), 32'(ce_s[i]));
         check_eq("rst_out_data", 32'(out_data_s[i]), 32'd0);
      end

      // DEPTH=3 back-to-back stream, latency exactly 3, no gaps
      lat_chk_s[0] = 1'b1;
      for (int b = 1; b <= 5; b++) begin
         in_valid_s[0] = 1'b1;
         in_data_s[0]  = W'(b);
         #1 check_eq("t1_in_ready", 32'(in_ready_s[0]), 32'd1);
         tick();
      end
      in_valid_s[0] = 1'b0;
      repeat (6) tick();
      lat_chk_s[0] = 1'b0;
      check_eq("t1_emitted", 32'(g_dut[0].n_out), 32'd5);

      // DEPTH=3 backpressure: 3 accepted, then full
      out_ready_s[0] = 1'b0;
      acc = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid_s[0] = 1'b1;
         in_data_s[0]  = W'(32'h10 + acc);
         #1;
         if (in_ready_s[0]) acc++;
         tick();
      end
      check_eq("t2_accepted", 32'(acc), 32'd3);
      check_eq("t2_in_ready_full", 32'(in_ready_s[0]), 32'd0);
      check_eq("t2_count_full", 32'(count_s[0]), 32'd3);
      check_eq("t2_hold_data", 32'(out_data_s[0]), 32'h10);
      out_ready_s[0] = 1'b1;
      #1 check_eq("t2_in_ready_drain", 32'(in_ready_s[0]), 32'd1);
      tick();
      in_valid_s[0] = 1'b0;
      repeat (5) tick();
      check_eq("t2_emitted", 32'(g_dut[0].n_out), 32'd9);

      // DEPTH=3 full chain frozen by ce=0 for two cycles
      out_ready_s[0] = 1'b0;
      for (int b = 0; b < 3; b++) begin
         in_valid_s[0] = 1'b1;
         in_data_s[0]  = W'(32'h20 + b);
         tick();
      end
      in_valid_s[0] = 1'b0;
      #1 check_eq("t3_count_full", 32'(count_s[0]), 32'd3);
      ce_s[0]        = 1'b0;
      out_ready_s[0] = 1'b1;
      #1;
      check_eq("t3_ce_out_valid", 32'(out_valid_s[0]), 32'd0);
      check_eq("t3_ce_in_ready", 32'(in_ready_s[0]), 32'd0);
      tick();
      check_eq("t3_ce_count1", 32'(count_s[0]), 32'd3);
      tick();
      check_eq("t3_ce_count2", 32'(count_s[0]), 32'd3);
      ce_s[0] = 1'b1;
      #1;
      check_eq("t3_resume_valid", 32'(out_valid_s[0]), 32'd1);
      check_eq("t3_resume_data", 32'(out_data_s[0]), 32'h20);
      repeat (5) tick();
      check_eq("t3_emitted", 32'(g_dut[0].n_out), 32'd12);

      // DEPTH=4 flush with two beats in flight and in_valid high
      for (int b = 0; b < 2; b++) begin
         in_valid_s[1] = 1'b1;
         in_data_s[1]  = W'(32'h30 + b);
         tick();
      end
      flush_s[1]   = 1'b1;
      in_data_s[1] = W'(32'h3F);
      #1;
      check_eq("t4_flush_in_ready", 32'(in_ready_s[1]), 32'd0);
      check_eq("t4_count_before", 32'(count_s[1]), 32'd2);
      tick();
      flush_s[1]    = 1'b0;
      in_valid_s[1] = 1'b0;
      #1;
      check_eq("t4_count_after", 32'(count_s[1]), 32'd0);
      check_eq("t4_out_valid", 32'(out_valid_s[1]), 32'd0);
      repeat (6) tick();
      check_eq("t4_emitted", 32'(g_dut[1].n_out), 32'd0);

      // DEPTH=2 reset mid-stream
      for (int b = 0; b < 3; b++) begin
         in_valid_s[2] = 1'b1;
         in_data_s[2]  = W'(32'h40 + b);
         tick();
      end
      in_valid_s[2] = 1'b0;
      rst_s[2]      = 1'b1;
      tick();
      rst_s[2] = 1'b0;
      #1;
      check_eq("t5_count", 32'(count_s[2]), 32'd0);
      check_eq("t5_out_data", 32'(out_data_s[2]), 32'd0);
      check_eq("t5_out_valid", 32'(out_valid_s[2]), 32'd0);
      check_eq("t5_in_ready", 32'(in_ready_s[2]), 32'd1);
      repeat (4) tick();
      check_eq("t5_emitted", 32'(g_dut[2].n_out), 32'd1);

      // DEPTH=0 pass-through
      lat_chk_s[3] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid_s[3]  = 1'($urandom_range(0, 1));
         out_ready_s[3] = 1'($urandom_range(0, 1));
         in_data_s[3]   = W'($urandom);
         #1;
         check_eq("t6_out_data", 32'(out_data_s[3]), 32'(in_data_s[3]));
         check_eq("t6_in_ready", 32'(in_ready_s[3]), 32'(out_ready_s[3]));
         check_eq("t6_out_valid", 32'(out_valid_s[3]), 32'(in_valid_s[3]));
         check_eq("t6_count", 32'(count_s[3]), 32'd0);
         tick();
      end
      ce_s[3]        = 1'b0;
      in_valid_s[3]  = 1'b1;
      out_ready_s[3] = 1'b1;
      #1;
      check_eq("t6_ce_out_valid", 32'(out_valid_s[3]), 32'd0);
      check_eq("t6_ce_in_ready", 32'(in_ready_s[3]), 32'd0);
      tick();
      ce_s[3]    = 1'b1;
      flush_s[3] = 1'b1;
      #1;
      check_eq("t6_flush_out_valid", 32'(out_valid_s[3]), 32'd0);
      check_eq("t6_flush_in_ready", 32'(in_ready_s[3]), 32'd0);
      tick();
      flush_s[3]    = 1'b0;
      in_valid_s[3] = 1'b0;
      lat_chk_s[3]  = 1'b0;

      // DEPTH=3 random valid/ready/ce/flush traffic against the scoreboard
      for (int c = 0; c < 300; c++) begin
         in_valid_s[0]  = ($urandom_range(0, 3) != 0);
         in_data_s[0]   = W'($urandom);
         out_ready_s[0] = ($urandom_range(0, 2) != 0);
         ce_s[0]        = ($urandom_range(0, 7) != 0);
         flush_s[0]     = ($urandom_range(0, 39) == 0);
         tick();
      end
      in_valid_s[0]  = 1'b0;
      out_ready_s[0] = 1'b1;
      ce_s[0]        = 1'b1;
      flush_s[0]     = 1'b0;
      repeat (6) tick();
      check_eq("stress_drained", 32'(g_dut[0].q.size()), 32'd0);
      check_eq("stress_count", 32'(count_s[0]), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
